// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache for the memory stage.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module data_cache #(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  funct3M,
    output logic [31:0] ReadDataM,
    output logic        StallCache,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int WB    = $clog2(LINE_WORDS);
    localparam int IB    = $clog2(SETS);
    localparam int TB    = 32 - 2 - WB - IB;
    localparam int DEPTH = SETS * LINE_WORDS;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t          state_q, state_d;
    logic [WB-1:0]   beat_q, beat_d;
    logic [SETS-1:0] valid_q, valid_d;

    logic [TB-1:0]   tag_mem  [SETS];
    logic [31:0]     data_mem [DEPTH];

    logic [WB-1:0]   a_word;
    logic [IB-1:0]   a_idx;
    logic [TB-1:0]   a_tag;
    logic            hit, is_load, is_store, last_beat;
    logic [31:0]     rd_word, ld_ext, st_data;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [3:0]      st_be;

    logic            wr_en, tag_we;
    logic [IB+WB-1:0] wr_addr;
    logic [31:0]     wr_data;

    assign a_word    = ALUResultM[2 +: WB];
    assign a_idx     = ALUResultM[2+WB +: IB];
    assign a_tag     = ALUResultM[31 -: TB];
    assign hit       = valid_q[a_idx] && (tag_mem[a_idx] == a_tag);
    assign is_store  = MemWriteM;
    assign is_load   = MemReadM & ~MemWriteM;
    assign rd_word   = data_mem[{a_idx, a_word}];
    assign last_beat = (beat_q == WB'(LINE_WORDS - 1));

    // Load lane select and extension.
    always_comb begin
        case (ALUResultM[1:0])
            2'd0:    ld_byte = rd_word[7:0];
            2'd1:    ld_byte = rd_word[15:8];
            2'd2:    ld_byte = rd_word[23:16];
            default: ld_byte = rd_word[31:24];
        endcase
        ld_half = ALUResultM[1] ? rd_word[31:16] : rd_word[15:0];
        case (funct3M)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'b0, ld_byte};
            3'b101:  ld_ext = {16'b0, ld_half};
            default: ld_ext = rd_word;
        endcase
    end

    // Store data is replicated across lanes; byte enables pick the live ones.
    always_comb begin
        st_be   = 4'b1111;
        st_data = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                st_be   = 4'b0001 << ALUResultM[1:0];
                st_data = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                st_be   = ALUResultM[1] ? 4'b1100 : 4'b0011;
                st_data = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (is_store) begin
                    state_d = WRITE;
                end else if (is_load && !hit) begin
                    state_d = REFILL;
                    beat_d  = '0;
                end
            end
            REFILL: begin
                if (mem_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        valid_d[a_idx] = 1'b1;
                        state_d        = IDLE;
                    end
                end
            end
            WRITE: begin
                if (mem_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ReadDataM  = '0;
        StallCache = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = '0;
        case (state_q)
            IDLE: begin
                StallCache = is_store | (is_load & ~hit);
                if (is_load && hit) ReadDataM = ld_ext;
            end
            REFILL: begin
                StallCache = 1'b1;
                mem_req    = 1'b1;
                mem_addr   = {a_tag, a_idx, beat_q, 2'b00};
            end
            WRITE: begin
                StallCache = ~mem_ready;
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = {ALUResultM[31:2], 2'b00};
                mem_wdata  = st_data;
                mem_be     = st_be;
            end
            default: ;
        endcase
    end

    // Single array write port: refill beats, or a byte merge on a store hit.
    always_comb begin
        wr_en   = 1'b0;
        tag_we  = 1'b0;
        wr_addr = {a_idx, a_word};
        wr_data = rd_word;
        if (state_q == REFILL && mem_ready) begin
            wr_en   = 1'b1;
            wr_addr = {a_idx, beat_q};
            wr_data = mem_rdata;
            tag_we  = last_beat;
        end else if (state_q == WRITE && mem_ready && hit) begin
            wr_en = 1'b1;
            for (int b = 0; b < 4; b++)
                if (st_be[b]) wr_data[8*b +: 8] = st_data[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)  data_mem[wr_addr] <= wr_data;
        if (tag_we) tag_mem[a_idx]    <= a_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == IDLE && is_load && hit)      hit_count_d  = hit_count_q + 32'd1;
        if (state_q == IDLE && state_d == REFILL)   miss_count_d = miss_count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus randomized traffic
// against a line-ownership / flat-memory reference model.
module tb_data_cache;
    localparam int SETS = 64;
    localparam int LW   = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0;
    logic [31:0] ALUResultM = '0, WriteDataM = '0;
    logic [2:0]  funct3M = 3'b010;
    logic [31:0] ReadDataM, mem_addr, mem_wdata;
    logic        StallCache, mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    data_cache #(.SETS(SETS), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .funct3M(funct3M),
        .ReadDataM(ReadDataM), .StallCache(StallCache), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef DCACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    int n_cmp = 0, n_bad = 0;

    // env_mem: backing memory as written by the DUT. ref_mem: what memory should hold.
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    longint      ref_line [SETS];
    int          ref_hits, ref_misses, leak_cnt;

    logic [31:0] bq_addr[$], bq_wd[$];
    logic        bq_we[$];
    logic [3:0]  bq_be[$];

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return (wa * 32'h9E3779B1) ^ 32'hC0FFEE11;
    endfunction
    function automatic logic [31:0] env_rd(input logic [31:0] wa);
        return env_mem.exists(wa) ? env_mem[wa] : init_word(wa);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] w, b, h;
        w = ref_rd(a >> 2);
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b ^ 32'h80) - 32'h80;
            3'b001:  return (h ^ 32'h8000) - 32'h8000;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (be[i]) m |= 32'hFF << (8 * i);
        return m;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) ref_line[s] = -1;
        ref_hits = 0;
        ref_misses = 0;
    endtask

    task automatic model_load(input logic [31:0] a, input logic [2:0] f3, input int dly,
                              output int est, output logic [31:0] ed);
        longint ln;
        int     s;
        ln = longint'(a >> (2 + $clog2(LW)));
        s  = int'(ln % SETS);
        if (ref_line[s] == ln) est = 0;
        else begin
            est = 1 + LW * (dly + 1);
            ref_line[s] = ln;
            ref_misses++;
        end
        ref_hits++;
        ed = exp_load(a, f3);
    endtask

    task automatic model_store(input logic [31:0] a, wd, input logic [2:0] f3,
                               output logic [3:0] ebe, output logic [31:0] elane);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   begin ebe = 4'b0001 << a[1:0]; elane = (wd & 32'hFF) << (8 * a[1:0]); end
            2'b01:   begin ebe = a[1] ? 4'b1100 : 4'b0011; elane = (wd & 32'hFFFF) << (16 * a[1]); end
            default: begin ebe = 4'b1111; elane = wd; end
        endcase
        w = ref_rd(a >> 2);
        w = (w & ~be_mask(ebe)) | (elane & be_mask(ebe));
        ref_mem[a >> 2] = w;
    endtask

    // Drives one request and plays backing memory until the cache stops stalling.
    task automatic access(input logic rd, wr, input logic [31:0] a, wd, input logic [2:0] f3,
                          input int dly, output int stalls, output logic [31:0] rdata);
        int          wcnt;
        bit          done;
        logic [31:0] w;
        stalls = 0; rdata = '0; wcnt = 0; done = 0;
        bq_addr.delete(); bq_wd.delete(); bq_we.delete(); bq_be.delete();
        @(negedge clk);
        MemReadM = rd; MemWriteM = wr; ALUResultM = a; WriteDataM = wd; funct3M = f3;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            if (cyc != 0) @(negedge clk);
            mem_ready = 1'b0;
            #1;
            if (mem_req) begin
                if (wcnt >= dly) begin
                    mem_ready = 1'b1;
                    wcnt = 0;
                    bq_addr.push_back(mem_addr); bq_we.push_back(mem_we);
                    bq_be.push_back(mem_be);     bq_wd.push_back(mem_wdata);
                    if (mem_we) begin
                        w = env_rd(mem_addr >> 2);
                        w = (w & ~be_mask(mem_be)) | (mem_wdata & be_mask(mem_be));
                        env_mem[mem_addr >> 2] = w;
                    end else mem_rdata = env_rd(mem_addr >> 2);
                end else wcnt++;
            end else if (mem_we || mem_addr != 0 || mem_wdata != 0 || mem_be != 0) leak_cnt++;
            #1;
            if (!StallCache) begin rdata = ReadDataM; done = 1; end
            else stalls++;
        end
    endtask

    task automatic seed_word(input logic [31:0] a, input logic [31:0] v);
        env_mem[a >> 2] = v;
        ref_mem[a >> 2] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        MemReadM = 0; MemWriteM = 0; mem_ready = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        leak_cnt = 0;
        #1;
        n_cmp++; if (StallCache !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", StallCache); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_cmp++; if (ReadDataM !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", ReadDataM); end
`ifdef DCACHE_STATS_EN
        n_cmp++; if (hit_count !== 0 || miss_count !== 0) begin n_bad++; $display("FAIL reset_stats: got %0d/%0d want 0/0", hit_count, miss_count); end
`endif
    endtask

    task automatic test_cold_load();
        int est, st;
        logic [31:0] ed, d;
        seed_word(32'h100, 32'hDEADBEEF);
        model_load(32'h100, 3'b010, 0, est, ed);
        access(1, 0, 32'h100, 0, 3'b010, 0, st, d);
        n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL cold_stall: got %0d want 5", st); end
        n_cmp++; if (d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL cold_data: got %h want deadbeef", d); end
        n_cmp++; if (bq_addr.size() !== LW) begin n_bad++; $display("FAIL cold_beats: got %0d want %0d", bq_addr.size(), LW); end
        for (int i = 0; i < bq_addr.size() && i < LW; i++) begin
            n_cmp++;
            if (bq_addr[i] !== 32'h100 + 32'(4 * i) || bq_we[i] !== 1'b0) begin
                n_bad++; $display("FAIL cold_beat_addr%0d: got %h we=%b want %h we=0", i, bq_addr[i], bq_we[i], 32'h100 + 4 * i);
            end
        end
        model_load(32'h104, 3'b010, 0, est, ed);
        access(1, 0, 32'h104, 0, 3'b010, 0, st, d);
        n_cmp++; if (st !== 0 || d !== ed) begin n_bad++; $display("FAIL cold_hit_next: got stall %0d data %h want 0 %h", st, d, ed); end
    endtask

    task automatic test_load_ext();
        int st, est;
        logic [31:0] d, ed, ln;
        logic [3:0] be;
        model_store(32'h100, 32'h80F17F01, 3'b010, be, ln);
        access(0, 1, 32'h100, 32'h80F17F01, 3'b010, 0, st, d);
        n_cmp++; if (bq_addr.size() !== 1 || st !== 1) begin n_bad++; $display("FAIL ext_setup_store: got beats %0d stall %0d want 1 1", bq_addr.size(), st); end
        model_load(32'h103, 3'b000, 0, est, ed);
        access(1, 0, 32'h103, 0, 3'b000, 0, st, d);
        n_cmp++; if (d !== 32'hFFFFFF80 || st !== 0) begin n_bad++; $display("FAIL ext_lb: got %h stall %0d want ffffff80 0", d, st); end
        model_load(32'h103, 3'b100, 0, est, ed);
        access(1, 0, 32'h103, 0, 3'b100, 0, st, d);
        n_cmp++; if (d !== 32'h00000080) begin n_bad++; $display("FAIL ext_lbu: got %h want 00000080", d); end
        model_load(32'h102, 3'b001, 0, est, ed);
        access(1, 0, 32'h102, 0, 3'b001, 0, st, d);
        n_cmp++; if (d !== 32'hFFFF80F1) begin n_bad++; $display("FAIL ext_lh: got %h want ffff80f1", d); end
        model_load(32'h100, 3'b101, 0, est, ed);
        access(1, 0, 32'h100, 0, 3'b101, 0, st, d);
        n_cmp++; if (d !== 32'h00007F01) begin n_bad++; $display("FAIL ext_lhu: got %h want 00007f01", d); end
    endtask

    task automatic test_store_hit();
        int st, est;
        logic [31:0] d, ed, ln;
        logic [3:0] be;
        model_store(32'h101, 32'hAA, 3'b000, be, ln);
        access(0, 1, 32'h101, 32'hAA, 3'b000, 3, st, d);
        n_cmp++; if (st !== 4) begin n_bad++; $display("FAIL sb_stall: got %0d want 4", st); end
        n_cmp++;
        if (bq_addr.size() !== 1 || bq_be[0] !== 4'b0010 || bq_wd[0][15:8] !== 8'hAA || bq_we[0] !== 1'b1 || bq_addr[0] !== 32'h100) begin
            n_bad++; $display("FAIL sb_beat: got n=%0d be=%b wd=%h addr=%h want 1 0010 xxxxAAxx 100", bq_addr.size(), bq_be[0], bq_wd[0], bq_addr[0]);
        end
        model_load(32'h100, 3'b010, 0, est, ed);
        access(1, 0, 32'h100, 0, 3'b010, 0, st, d);
        n_cmp++; if (d !== 32'h80F1AA01 || st !== 0) begin n_bad++; $display("FAIL sb_readback: got %h stall %0d want 80f1aa01 0", d, st); end
    endtask

    task automatic test_store_miss();
        int st, est;
        logic [31:0] d, ed, ln;
        logic [3:0] be;
        model_store(32'h2000, 32'h12345678, 3'b010, be, ln);
        access(0, 1, 32'h2000, 32'h12345678, 3'b010, 0, st, d);
        n_cmp++;
        if (bq_addr.size() !== 1 || bq_be[0] !== 4'hF || bq_wd[0] !== 32'h12345678) begin
            n_bad++; $display("FAIL sw_miss_beat: got n=%0d be=%b wd=%h want 1 1111 12345678", bq_addr.size(), bq_be[0], bq_wd[0]);
        end
        model_load(32'h2000, 3'b010, 0, est, ed);
        access(1, 0, 32'h2000, 0, 3'b010, 0, st, d);
        n_cmp++; if (st !== 5 || d !== 32'h12345678) begin n_bad++; $display("FAIL sw_miss_noalloc: got stall %0d data %h want 5 12345678", st, d); end
    endtask

    task automatic test_conflict();
        int st, est;
        logic [31:0] d, ed;
        logic [31:0] far;
        far = 32'h100 + 32'(SETS * LW * 4);
        model_load(32'h100, 3'b010, 0, est, ed);
        access(1, 0, 32'h100, 0, 3'b010, 0, st, d);
        n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL conf_first_hit: got stall %0d want 0", st); end
        model_load(far, 3'b010, 0, est, ed);
        access(1, 0, far, 0, 3'b010, 0, st, d);
        n_cmp++; if (st !== 5 || d !== ed) begin n_bad++; $display("FAIL conf_evict: got stall %0d data %h want 5 %h", st, d, ed); end
        model_load(32'h100, 3'b010, 1, est, ed);
        access(1, 0, 32'h100, 0, 3'b010, 1, st, d);
        n_cmp++; if (st !== 9 || d !== 32'h80F1AA01) begin n_bad++; $display("FAIL conf_reload: got stall %0d data %h want 9 80f1aa01", st, d); end
    endtask

    task automatic test_random();
        logic [31:0] bases [6];
        int          st, est, dly, kind;
        logic [31:0] a, wd, d, ed, ln, m;
        logic [2:0]  f3;
        logic [3:0]  be;
        logic [2:0]  lf3 [5];
        bases = '{32'h100, 32'h500, 32'h900, 32'h2000, 32'h6000, 32'h3F0};
        lf3   = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int n = 0; n < 400; n++) begin
            a    = bases[$urandom_range(0, 5)] + 32'($urandom_range(0, 15));
            dly  = $urandom_range(0, 2);
            kind = $urandom_range(0, 9);
            wd   = $urandom;
            if (kind < 6) begin
                f3 = lf3[$urandom_range(0, 4)];
                model_load(a, f3, dly, est, ed);
                access(1, 0, a, 0, f3, dly, st, d);
                n_cmp++; if (st !== est || d !== ed) begin n_bad++; $display("FAIL rand_load a=%h f3=%b: got stall %0d data %h want %0d %h", a, f3, st, d, est, ed); end
            end else begin
                f3 = 3'($urandom_range(0, 2));
                model_store(a, wd, f3, be, ln);
                m = be_mask(be);
                access(kind == 9, 1, a, wd, f3, dly, st, d);
                n_cmp++;
                if (st !== 1 + dly || bq_addr.size() !== 1 || bq_addr[0] !== {a[31:2], 2'b00} || bq_be[0] !== be || (bq_wd[0] & m) !== (ln & m)) begin
                    n_bad++; $display("FAIL rand_store a=%h f3=%b: got stall %0d n=%0d addr=%h be=%b wd=%h want %0d 1 %h %b %h", a, f3, st, bq_addr.size(), bq_addr[0], bq_be[0], bq_wd[0], 1 + dly, {a[31:2], 2'b00}, be, ln);
                end
            end
        end
        n_cmp++; if (leak_cnt !== 0) begin n_bad++; $display("FAIL mem_idle_zero: got %0d leaks want 0", leak_cnt); end
`ifdef DCACHE_STATS_EN
        n_cmp++; if (hit_count !== 32'(ref_hits) || miss_count !== 32'(ref_misses)) begin n_bad++; $display("FAIL rand_stats: got %0d/%0d want %0d/%0d", hit_count, miss_count, ref_hits, ref_misses); end
`endif
    endtask

    task automatic test_reset_mid_refill();
        int beats, st, est;
        logic [31:0] d, ed;
        beats = 0;
        @(negedge clk);
        MemReadM = 1; MemWriteM = 0; ALUResultM = 32'h7050; funct3M = 3'b010;
        for (int cyc = 0; cyc < 20 && beats < 3; cyc++) begin
            if (cyc != 0) @(negedge clk);
            mem_ready = 1'b0;
            #1;
            if (mem_req) begin mem_ready = 1'b1; mem_rdata = env_rd(mem_addr >> 2); beats++; end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_cmp++; if (beats !== 3 || mem_req !== 1'b1) begin n_bad++; $display("FAIL mid_pre: got beats %0d req %b want 3 1", beats, mem_req); end
        rst = 1'b1;
        #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL mid_req_drop: got %b want 0", mem_req); end
        MemReadM = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        model_load(32'h7050, 3'b010, 0, est, ed);
        access(1, 0, 32'h7050, 0, 3'b010, 0, st, d);
        n_cmp++; if (st !== 5 || bq_addr.size() !== LW || d !== ed) begin n_bad++; $display("FAIL mid_refill_again: got stall %0d beats %0d data %h want 5 %0d %h", st, bq_addr.size(), d, LW, ed); end
`ifdef DCACHE_STATS_EN
        n_cmp++; if (miss_count !== 32'd1 || hit_count !== 32'd1) begin n_bad++; $display("FAIL mid_stats: got %0d/%0d want 1/1", hit_count, miss_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_load_ext();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_random();
        test_reset_mid_refill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
